audio_mixer_seq: RTL and testbench
==================================

// Module: audio_mixer_seq
// PURPOSE
//  Time-multiplexed N-channel audio mixer, successor to the 4-ch shift mixer.
//  - Per channel: volume multiply (not shift), mute mask, master gain.
//  - Signed or unsigned samples; saturating output with sticky clip/overrun flags.
//  - One mix frame per sample_tick, on a snapshot of all channel inputs.
//  - Sits between the tone/PCM generators and the PWM/DAC driver; configured over the CPU valid/ready bus.
// PARAMETERS
//  N_CH      8   channel count, 1..16
//  IN_W      8   channel sample width
//  VOL_W     4   channel/master volume width
//  OUT_W     12  output width
//  CALC_CNT  2   cycles spent per channel, 1..15
// PORTS
//  clk          in   1           clock
//  resetn       in   1           synchronous, active-low reset
//  valid        in   1           bus request
//  ready        out  1           bus ack, 1-cycle pulse
//  wstrb        in   4           write strobes, nonzero = write
//  addr         in   32          byte address; word index = addr[7:2]
//  wdata        in   32          write data
//  rdata        out  32          read data
//  ch_data      in   N_CH*IN_W   packed samples; ch i = [i*IN_W +: IN_W]
//  sample_tick  in   1           frame start request
//  out          out  OUT_W       mixed sample, held between frames
//  out_valid    out  1           1-cycle pulse when out updates
//  busy         out  1           frame in progress
// BEHAVIOUR
//  Reset: all outputs 0. CTRL=0, MUTE=0, STATUS=0, channel VOL=0, MASTER=all ones.
//    A frame in progress is aborted; no out_valid.
//  Register map (word index):
//    0 CTRL    b0 enable, b1 signed
//    1 MUTE    [N_CH-1:0]
//    2 MASTER  [VOL_W-1:0]
//    3 STATUS  b0 busy (RO), b1 overrun, b2 clip; both W1C
//    4+i VOL[i] for i < N_CH
//    Unmapped: reads 0, writes ignored.
//  Bus: valid && !ready -> next cycle ready=1, rdata valid, write committed.
//    ready is low the following cycle. Master drops valid after ready.
//  FSM: IDLE -> ACC -> MASTER -> OUT -> IDLE.
//    IDLE: sample_tick && enable -> snapshot ch_data, MUTE, VOL[], MASTER, signed;
//      acc=0; busy=1; go to ACC.
//    ACC: channel k occupies CALC_CNT cycles.
//      On its last cycle: acc += muted ? 0 : sample_k * VOL[k].
//      VOL is unsigned. sample is sign-extended if signed, else zero-extended.
//      Muted channels still consume CALC_CNT cycles (fixed latency).
//    MASTER: 1 cycle; acc = (acc * (MASTER+1)) >>> VOL_W (arithmetic shift).
//    OUT: 1 cycle; out <= sat(acc); out_valid pulses next cycle; busy=0; go to IDLE.
//  Widths:
//    acc = IN_W+VOL_W+clog2(N_CH)+2 bits, signed; no internal overflow is possible.
//    sat, unsigned mode: clamp to [0, 2^OUT_W-1].
//    sat, signed mode: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out is two's complement.
//    Any clamp sets STATUS.clip.
//  Latency: tick accepted in cycle 0 -> out_valid high in cycle N_CH*CALC_CNT+3.
//  Boundaries:
//    tick while busy: ignored; STATUS.overrun=1.
//    tick while !enable: ignored, no flag.
//    enable cleared mid-frame: frame completes.
//    Config or ch_data change mid-frame: no effect until next frame (snapshot).
//    Bus write of a W1C bit in the same cycle a flag sets: set wins.
// TESTING (N_CH=4, IN_W=8, VOL_W=4, OUT_W=12, CALC_CNT=2)
//  1 Reset, read words 0..7 -> CTRL=0, MUTE=0, MASTER=0xF, STATUS=0, VOL=0.
//    out=0, out_valid=0.
//  2 Unsigned, ch0=100, VOL0=3, MUTE=0xE, MASTER=15, tick at cycle 0
//    -> out_valid at cycle 11, out=300, clip=0.
//  3 Unsigned, all ch=255, VOL=15 -> out=4095, clip=1.
//    Write STATUS=0x4 -> clip=0.
//  4 Signed, ch0=0x80, VOL0=15, others muted -> out=0x880 (-1920).
//    All four ch=0x80 -> out=0x800, clip=1.
//  5 Second tick at frame cycle 5 -> exactly one out_valid; STATUS.overrun=1.
//    ch_data change at cycle 3 does not alter out.
//  6 resetn low at frame cycle 4 -> no out_valid, busy=0, out=0.
//    Next tick produces a normal frame.

Source files
------------

// File: rtl/audio_mixer_seq_if.sv
// CPU-side valid/ready register bus of the audio mixer.
interface audio_mixer_seq_if;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output valid, wstrb, addr, wdata, input ready, rdata);
  modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/audio_mixer_seq.sv
// Time-multiplexed N-channel audio mixer: per-channel volume multiply, mute mask,
// master gain, saturating output, frame per sample_tick on a snapshot of inputs.
module audio_mixer_seq #(
  parameter int N_CH     = 8,
  parameter int IN_W     = 8,
  parameter int VOL_W    = 4,
  parameter int OUT_W    = 12,
  parameter int CALC_CNT = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  audio_mixer_seq_if.slave       bus,
  input  logic [N_CH*IN_W-1:0]   ch_data,
  input  logic                   sample_tick,
  output logic [OUT_W-1:0]       out,
  output logic                   out_valid,
  output logic                   busy
);
  localparam int ACC_W = IN_W + VOL_W + $clog2(N_CH) + 2;
  localparam int PRD_W = ACC_W + VOL_W + 1;
  localparam int CW    = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 2;
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = $clog2(CALC_CNT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_MASTER, S_OUT} state_t;
  state_t state, state_nxt;

  logic              ctrl_en, ctrl_signed, overrun, clip;
  logic [N_CH-1:0]   mute, snap_mute;
  logic [VOL_W-1:0]  master, snap_master;
  logic [VOL_W-1:0]  vol [N_CH];
  logic [VOL_W-1:0]  snap_vol [N_CH];
  logic [N_CH*IN_W-1:0] snap_data;
  logic              snap_signed;
  logic [CH_W-1:0]   ch_idx;
  logic [CNT_W-1:0]  cnt;
  logic signed [ACC_W-1:0] acc;

  logic        last_step, bus_acc, bus_wr, vol_hit;
  logic [5:0]  widx, vidx;
  logic [31:0] rd_mux;
  logic        unused_bits;

  assign busy      = (state != S_IDLE);
  assign last_step = (cnt == CNT_W'(CALC_CNT - 1));
  assign bus_acc   = bus.valid && !bus.ready;
  assign bus_wr    = bus_acc && (|bus.wstrb);
  assign widx      = bus.addr[7:2];
  assign vidx      = widx - 6'd4;
  assign vol_hit   = (widx >= 6'd4) && (32'(widx) < 32'(N_CH + 4));
  assign unused_bits = ^{bus.addr, bus.wdata};

  // Per-channel term, master scaling and saturation datapath
  logic [IN_W-1:0]          smp;
  logic signed [ACC_W-1:0]  smp_ext, vol_ext, term_mul, term;
  logic [VOL_W:0]           mgain;
  logic signed [PRD_W-1:0]  acc_x, mg_x, prod, scaled;
  logic signed [CW-1:0]     acc_c, hi, lo;
  logic [OUT_W-1:0]         sat_val;
  logic                     sat_clip;

  always_comb begin
    smp      = snap_data[ch_idx*IN_W +: IN_W];
    smp_ext  = {{(ACC_W-IN_W){snap_signed & smp[IN_W-1]}}, smp};
    vol_ext  = {{(ACC_W-VOL_W){1'b0}}, snap_vol[ch_idx]};
    term_mul = smp_ext * vol_ext;
    term     = snap_mute[ch_idx] ? '0 : term_mul;

    mgain  = {1'b0, snap_master} + 1'b1;
    acc_x  = {{(PRD_W-ACC_W){acc[ACC_W-1]}}, acc};
    mg_x   = {{(PRD_W-VOL_W-1){1'b0}}, mgain};
    prod   = acc_x * mg_x;
    scaled = prod >>> VOL_W;

    acc_c = {{(CW-ACC_W){acc[ACC_W-1]}}, acc};
    if (snap_signed) begin
      hi = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      lo = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    end else begin
      hi = {{(CW-OUT_W){1'b0}}, {OUT_W{1'b1}}};
      lo = '0;
    end
    sat_clip = 1'b1;
    if (acc_c > hi)      sat_val = hi[OUT_W-1:0];
    else if (acc_c < lo) sat_val = lo[OUT_W-1:0];
    else begin
      sat_val  = acc_c[OUT_W-1:0];
      sat_clip = 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (widx)
      6'd0: rd_mux[1:0] = {ctrl_signed, ctrl_en};
      6'd1: rd_mux[N_CH-1:0] = mute;
      6'd2: rd_mux[VOL_W-1:0] = master;
      6'd3: rd_mux[2:0] = {clip, overrun, busy};
      default: if (vol_hit) rd_mux[VOL_W-1:0] = vol[vidx[CH_W-1:0]];
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (sample_tick && ctrl_en) state_nxt = S_ACC;
      S_ACC:    if (last_step && ch_idx == CH_W'(N_CH - 1)) state_nxt = S_MASTER;
      S_MASTER: state_nxt = S_OUT;
      S_OUT:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out <= '0; out_valid <= 1'b0; acc <= '0; cnt <= '0; ch_idx <= '0;
      ctrl_en <= 1'b0; ctrl_signed <= 1'b0; overrun <= 1'b0; clip <= 1'b0;
      mute <= '0; master <= '1; snap_mute <= '0; snap_master <= '0;
      snap_data <= '0; snap_signed <= 1'b0;
      bus.ready <= 1'b0; bus.rdata <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        vol[i] <= '0;
        snap_vol[i] <= '0;
      end
    end else begin
      out_valid <= (state == S_OUT);
      case (state)
        S_IDLE: if (sample_tick && ctrl_en) begin
          snap_data <= ch_data; snap_mute <= mute; snap_vol <= vol;
          snap_master <= master; snap_signed <= ctrl_signed;
          acc <= '0; cnt <= '0; ch_idx <= '0;
        end
        S_ACC: if (last_step) begin
          acc <= acc + term;
          cnt <= '0;
          ch_idx <= ch_idx + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        S_MASTER: acc <= scaled[ACC_W-1:0];
        S_OUT:    out <= sat_val;
        default: ;
      endcase

      bus.ready <= bus_acc;
      if (bus_acc) bus.rdata <= rd_mux;
      if (bus_wr) begin
        case (widx)
          6'd0: begin ctrl_en <= bus.wdata[0]; ctrl_signed <= bus.wdata[1]; end
          6'd1: mute <= bus.wdata[N_CH-1:0];
          6'd2: master <= bus.wdata[VOL_W-1:0];
          6'd3: begin
            if (bus.wdata[1]) overrun <= 1'b0;
            if (bus.wdata[2]) clip <= 1'b0;
          end
          default: if (vol_hit) vol[vidx[CH_W-1:0]] <= bus.wdata[VOL_W-1:0];
        endcase
      end
      // Flag sets come after the W1C clears so a same-cycle set wins
      if (sample_tick && state != S_IDLE) overrun <= 1'b1;
      if (state == S_OUT && sat_clip)     clip <= 1'b1;
    end
  end
endmodule

// File: tb/tb_audio_mixer_seq.sv
// Directed self-checking bench for audio_mixer_seq (4 channels, 8-bit samples, 12-bit out).
module tb_audio_mixer_seq;
  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] ch_data;
  logic        sample_tick;
  logic [11:0] out;
  logic        out_valid;
  logic        busy;
  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;

  audio_mixer_seq_if bus();

  audio_mixer_seq #(.N_CH(4), .IN_W(8), .VOL_W(4), .OUT_W(12), .CALC_CNT(2)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .ch_data(ch_data),
    .sample_tick(sample_tick), .out(out), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d, input bit wr,
                          output logic [31:0] rd);
    int n = 0;
    bus.valid = 1'b1; bus.addr = a; bus.wdata = d; bus.wstrb = wr ? 4'hF : 4'h0;
    do begin step(); n++; end while (!bus.ready && n < 8);
    check("bus_ready", bus.ready, 1);
    rd = bus.rdata;
    bus.valid = 1'b0; bus.wstrb = 4'h0;
    step();
    check("ready_drop", bus.ready, 0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus_xfer(a, d, 1'b1, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_xfer(a, 32'h0, 1'b0, v);
    check(tag, v, exp);
  endtask

  // One frame: tick in cycle 0, expect out_valid in cycle 11 with the given sample
  task automatic do_frame(input string tag, input logic [11:0] exp_out);
    int n0;
    sample_tick = 1'b1; n0 = cyc_cnt;
    step();
    sample_tick = 1'b0;
    check({tag, "_busy"}, busy, 1);
    while (!out_valid && cyc_cnt - n0 < 40) step();
    check({tag, "_lat"}, out_valid ? cyc_cnt - n0 : -1, 11);
    check({tag, "_out"}, out, exp_out);
    check({tag, "_idle"}, busy, 0);
    step();
    check({tag, "_pulse"}, out_valid, 0);
  endtask

  initial begin
    int n0, pulses, lat, c;
    resetn = 1'b0; ch_data = '0; sample_tick = 1'b0;
    bus.valid = 1'b0; bus.wstrb = '0; bus.addr = '0; bus.wdata = '0;
    repeat (3) step();
    check("rst_out", out, 0);
    check("rst_ov", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", bus.ready, 0);
    resetn = 1'b1;
    step();

    rd_chk("rst_ctrl", 32'h00, 0);
    rd_chk("rst_mute", 32'h04, 0);
    rd_chk("rst_master", 32'h08, 32'hF);
    rd_chk("rst_status", 32'h0C, 0);
    for (int i = 0; i < 4; i++) rd_chk("rst_vol", 32'h10 + 4 * i, 0);
    wr(32'h20, 32'hF);
    rd_chk("unmapped", 32'h20, 0);

    // Unsigned single channel: 100*3, master 15 -> 300
    wr(32'h00, 32'h1); wr(32'h10, 32'h3); wr(32'h04, 32'hE);
    rd_chk("vol0_rb", 32'h10, 3);
    ch_data = 32'h0000_0064;
    do_frame("uns1", 12'd300);
    check("uns1_hold", out, 300);
    rd_chk("uns1_status", 32'h0C, 0);

    // Master 7: 300*8>>4 = 150
    wr(32'h08, 32'h7);
    do_frame("mst7", 12'd150);
    wr(32'h08, 32'hF);

    // Unsigned full scale clamps
    ch_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) wr(32'h10 + 4 * i, 32'hF);
    wr(32'h04, 32'h0);
    do_frame("uns_sat", 12'hFFF);
    rd_chk("clip_set", 32'h0C, 32'h4);
    wr(32'h0C, 32'h4);
    rd_chk("clip_w1c", 32'h0C, 0);

    // Signed: -128*15 = -1920; four of them clamp to -2048
    wr(32'h00, 32'h3); wr(32'h04, 32'hE);
    ch_data = 32'h0000_0080;
    do_frame("sgn1", 12'h880);
    rd_chk("sgn1_status", 32'h0C, 0);
    ch_data = 32'h8080_8080; wr(32'h04, 32'h0);
    do_frame("sgn_sat", 12'h800);
    rd_chk("sgn_clip", 32'h0C, 32'h4);
    wr(32'h0C, 32'h4);

    // Arithmetic shift of a negative product: -1*1*1 >>> 4 = -1
    ch_data = 32'h0000_00FF; wr(32'h10, 32'h1); wr(32'h08, 32'h0); wr(32'h04, 32'hE);
    do_frame("ashr", 12'hFFF);
    rd_chk("ashr_status", 32'h0C, 0);
    wr(32'h08, 32'hF);

    // Overrun tick at cycle 5 and ch_data change at cycle 3
    wr(32'h00, 32'h1); wr(32'h10, 32'h3);
    ch_data = 32'h0000_0064;
    sample_tick = 1'b1; n0 = cyc_cnt;
    step();
    pulses = 0; lat = -1;
    while (cyc_cnt - n0 < 26) begin
      c = cyc_cnt - n0;
      if (out_valid) begin pulses++; lat = c; end
      if (c == 3) ch_data = 32'h0000_0032;
      sample_tick = (c == 5);
      step();
    end
    check("ovr_pulses", pulses, 1);
    check("ovr_lat", lat, 11);
    check("ovr_out", out, 300);
    rd_chk("ovr_status", 32'h0C, 32'h2);
    wr(32'h0C, 32'h6);
    rd_chk("ovr_w1c", 32'h0C, 0);

    // Tick while disabled: nothing happens
    wr(32'h00, 32'h0);
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    check("dis_busy", busy, 0);
    pulses = 0;
    repeat (15) begin step(); if (out_valid) pulses++; end
    check("dis_pulses", pulses, 0);
    rd_chk("dis_status", 32'h0C, 0);

    // Disable and reconfigure mid-frame: frame completes on the snapshot
    wr(32'h00, 32'h1);
    ch_data = 32'h0000_0064;
    sample_tick = 1'b1; n0 = cyc_cnt; step(); sample_tick = 1'b0;
    wr(32'h00, 32'h0); wr(32'h10, 32'h9);
    ch_data = 32'h0000_0011;
    while (!out_valid && cyc_cnt - n0 < 40) step();
    check("mid_lat", out_valid ? cyc_cnt - n0 : -1, 11);
    check("mid_out", out, 300);

    // Reset at frame cycle 4 aborts the frame
    wr(32'h00, 32'h1); wr(32'h10, 32'h3);
    ch_data = 32'h0000_0064;
    sample_tick = 1'b1; n0 = cyc_cnt; step(); sample_tick = 1'b0;
    while (cyc_cnt - n0 < 4) step();
    resetn = 1'b0; step();
    check("abort_busy", busy, 0);
    check("abort_out", out, 0);
    check("abort_ov", out_valid, 0);
    resetn = 1'b1;
    pulses = 0;
    repeat (15) begin step(); if (out_valid) pulses++; end
    check("abort_pulses", pulses, 0);
    wr(32'h00, 32'h1); wr(32'h10, 32'h3); wr(32'h04, 32'hE);
    do_frame("post_rst", 12'd300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
